// File: rtl/comp_pkg.sv
// Shared constants for the bit-serial comparator feeder and its models.
package comp_pkg;
    localparam int WIDTH_MAX = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
endpackage

// File: rtl/comp_piso.sv
// Parallel-load, shift-left register presenting its MSB as the serial output.
module comp_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= din;
        end else if (shift) begin
            data_reg <= {data_reg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = data_reg[WIDTH-1];
endmodule

// File: rtl/comp_seq_feeder.sv
// Sequences the bit-serial comparator: clear, stream both operands MSB-first,
// then capture its flags as a one-hot lt/eq/gt result behind a handshake.
module comp_seq_feeder
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_clr,
    input  logic             lgn_in,
    input  logic             e_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             msb_a;
    logic             msb_b;
    logic             load;
    logic             shift;
    logic             last;

    assign load  = (state_reg == ST_IDLE) && in_valid;
    assign shift = (state_reg == ST_SHIFT);
    assign last  = (cnt_reg == CNT_W'(WIDTH - 1));

    comp_piso #(.WIDTH(WIDTH)) u_piso_a (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_a),
        .msb   (msb_a)
    );

    comp_piso #(.WIDTH(WIDTH)) u_piso_b (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_b),
        .msb   (msb_b)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (in_valid) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = ST_SHIFT;
            ST_SHIFT:  if (last) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_DONE;
            ST_DONE:   if (res_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counter holds at WIDTH-1 on the final shift so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg == ST_CLEAR) begin
            cnt_reg <= '0;
        end else if (shift && !last) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_lt <= 1'b0;
            res_eq <= 1'b0;
            res_gt <= 1'b0;
        end else if (state_reg == ST_SAMPLE) begin
            res_lt <= lgn_in;
            res_eq <= e_in;
            res_gt <= ~lgn_in & ~e_in;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign ser_clr   = (state_reg == ST_IDLE) || (state_reg == ST_CLEAR);
    assign ser_a     = shift & msb_a;
    assign ser_b     = shift & msb_b;
    assign res_valid = (state_reg == ST_DONE);
endmodule

// File: tb/tb_comp_seq_feeder.sv
// Directed and randomised checks of comp_seq_feeder against a behavioural comparator.
module tb_comp_seq_feeder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_a;
    logic         ser_b;
    logic         ser_clr;
    logic         lgn_in;
    logic         e_in;
    logic         res_valid;
    logic         res_ready;
    logic         res_lt;
    logic         res_eq;
    logic         res_gt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    comp_seq_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_clr   (ser_clr),
        .lgn_in    (lgn_in),
        .e_in      (e_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_lt    (res_lt),
        .res_eq    (res_eq),
        .res_gt    (res_gt)
    );

    // MSB-first comparator: first differing bit decides, clear is synchronous.
    always_ff @(posedge clk) begin
        if (ser_clr) begin
            lgn_in <= 1'b0;
            e_in   <= 1'b1;
        end else if (e_in && (ser_a != ser_b)) begin
            e_in   <= 1'b0;
            lgn_in <= ser_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] expect_res(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a < b, a == b, a > b};
    endfunction

    // Sends one pair, follows it to the result, holds res_ready low for
    // 'hold' cycles, then completes the result handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit check_lat);
        int           k;
        int           clr_cycles;
        logic [W-1:0] got_a;
        logic [W-1:0] got_b;
        logic [2:0]   exp_r;
        exp_r = expect_res(a, b);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("accept_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        // k counts edges after the accept edge.
        k = 0;
        clr_cycles = 0;
        got_a = '0;
        got_b = '0;
        while (!res_valid && k < 40) begin
            if (ser_clr) clr_cycles++;
            if (k >= 1 && k <= W) begin
                got_a = {got_a[W-2:0], ser_a};
                got_b = {got_b[W-2:0], ser_b};
            end
            tick();
            k++;
        end
        check("res_valid_seen", res_valid, 1'b1);
        if (check_lat) check("latency_incl_accept", k + 1, W + 3);
        check("clr_once", clr_cycles, 1);
        check("ser_a_stream", got_a, a);
        check("ser_b_stream", got_b, b);
        check("result", {res_lt, res_eq, res_gt}, exp_r);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_stable", {res_valid, in_ready, res_lt, res_eq, res_gt}, {2'b10, exp_r});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("ready_after_hs", {in_ready, res_valid}, 2'b10);
        $display("op a=%02h b=%02h lt/eq/gt=%b exp=%b hold=%0d", a, b,
                 {res_lt, res_eq, res_gt}, exp_r, hold);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("reset_state", {in_ready, ser_clr, ser_a, ser_b, res_valid, res_lt, res_eq, res_gt},
              8'b1100_0000);
        reset = 1'b0;
        tick();

        run_op(8'h5A, 8'h5A, 0, 1'b1);
        run_op(8'h80, 8'h7F, 0, 1'b1);
        run_op(8'h7F, 8'h80, 0, 1'b0);
        run_op(8'h00, 8'h01, 0, 1'b0);
        run_op(8'hFF, 8'hFE, 20, 1'b0);

        // Abort mid-shift: accept, then reset during shift cycle 4.
        in_a = 8'hFF;
        in_b = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset_ser", {ser_clr, ser_a, ser_b}, 3'b011);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {in_ready, ser_clr, ser_a, ser_b, res_valid, res_lt, res_eq, res_gt},
              8'b1100_0000);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_idle", {in_ready, res_valid}, 2'b10);
        run_op(8'h10, 8'h20, 0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            ra = W'($urandom);
            rb = (n % 8 == 0) ? ra : W'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
